// File: rtl/cpu_control.sv
// Multicycle control FSM for the RV32I datapath. It sequences fetch, decode, execute and memory
// phases, and drives the datapath load enables, mux selects, ALU/CMP ops and the memory handshake.
module cpu_control (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  input  logic       br_en,
  input  logic [1:0] mem_addr_mask,
  input  logic       mem_resp,
  output logic       load_pc,
  output logic       load_ir,
  output logic       load_regfile,
  output logic       load_mar,
  output logic       load_mdr,
  output logic       load_data_out,
  output logic [1:0] pcmux_sel,
  output logic       alumux1_sel,
  output logic [2:0] alumux2_sel,
  output logic [3:0] regfilemux_sel,
  output logic       marmux_sel,
  output logic       cmpmux_sel,
  output logic [2:0] aluop,
  output logic [2:0] cmpop,
  output logic       mem_read,
  output logic       mem_write,
  output logic [3:0] mem_byte_enable
);

  localparam logic [6:0] OpLui   = 7'b0110111;
  localparam logic [6:0] OpAuipc = 7'b0010111;
  localparam logic [6:0] OpJal   = 7'b1101111;
  localparam logic [6:0] OpJalr  = 7'b1100111;
  localparam logic [6:0] OpBr    = 7'b1100011;
  localparam logic [6:0] OpLoad  = 7'b0000011;
  localparam logic [6:0] OpStore = 7'b0100011;
  localparam logic [6:0] OpImm   = 7'b0010011;
  localparam logic [6:0] OpReg   = 7'b0110011;

  localparam logic [1:0] PcPlus4  = 2'd0;
  localparam logic [1:0] PcAluOut = 2'd1;
  localparam logic [1:0] PcAluMod2 = 2'd2;

  localparam logic Alu1Rs1 = 1'b0;
  localparam logic Alu1Pc  = 1'b1;

  localparam logic [2:0] Alu2IImm = 3'd0;
  localparam logic [2:0] Alu2UImm = 3'd1;
  localparam logic [2:0] Alu2BImm = 3'd2;
  localparam logic [2:0] Alu2SImm = 3'd3;
  localparam logic [2:0] Alu2JImm = 3'd4;
  localparam logic [2:0] Alu2Rs2  = 3'd5;

  localparam logic [3:0] RfAluOut  = 4'd0;
  localparam logic [3:0] RfBrEn    = 4'd1;
  localparam logic [3:0] RfUImm    = 4'd2;
  localparam logic [3:0] RfLw      = 4'd3;
  localparam logic [3:0] RfPcPlus4 = 4'd4;
  localparam logic [3:0] RfLb      = 4'd5;
  localparam logic [3:0] RfLbu     = 4'd6;
  localparam logic [3:0] RfLh      = 4'd7;
  localparam logic [3:0] RfLhu     = 4'd8;

  localparam logic MarPc  = 1'b0;
  localparam logic MarAlu = 1'b1;
  localparam logic CmpRs2  = 1'b0;
  localparam logic CmpIImm = 1'b1;

  localparam logic [2:0] AluAdd = 3'b000;
  localparam logic [2:0] AluSra = 3'b010;
  localparam logic [2:0] AluSub = 3'b011;
  localparam logic [2:0] CmpBlt  = 3'b100;
  localparam logic [2:0] CmpBltu = 3'b110;

  typedef enum logic [4:0] {
    StFetch1, StFetch2, StFetch3, StDecode, StImm, StReg, StLui, StAuipc, StBr, StJal, StJalr,
    StNop, StCalcAddr, StLd1, StLd2, StSt1, StSt2
  } state_e;

  state_e state_q, state_d;

  // Only funct7[5] distinguishes sub/sra from add/srl.
  logic unused_funct7;
  assign unused_funct7 = ^{funct7[6], funct7[4:0]};

  // State register; reset parks the FSM in FETCH1.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= StFetch1;
    else      state_q <= state_d;
  end

  // Next-state: memory states hold until mem_resp, execute states return to FETCH1.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StFetch1: state_d = StFetch2;
      StFetch2: if (mem_resp) state_d = StFetch3;
      StFetch3: state_d = StDecode;
      StDecode: begin
        case (opcode)
          OpImm:            state_d = StImm;
          OpReg:            state_d = StReg;
          OpLui:            state_d = StLui;
          OpAuipc:          state_d = StAuipc;
          OpBr:             state_d = StBr;
          OpJal:            state_d = StJal;
          OpJalr:           state_d = StJalr;
          OpLoad, OpStore:  state_d = StCalcAddr;
          default:          state_d = StNop;
        endcase
      end
      StCalcAddr: state_d = (opcode == OpStore) ? StSt1 : StLd1;
      StLd1:      if (mem_resp) state_d = StLd2;
      StSt1:      if (mem_resp) state_d = StSt2;
      default:    state_d = StFetch1;
    endcase
  end

  // Datapath controls decoded from state and IR fields; reset squashes loads and requests.
  always_comb begin
    load_pc         = 1'b0;
    load_ir         = 1'b0;
    load_regfile    = 1'b0;
    load_mar        = 1'b0;
    load_mdr        = 1'b0;
    load_data_out   = 1'b0;
    mem_read        = 1'b0;
    mem_write       = 1'b0;
    mem_byte_enable = 4'b0000;
    pcmux_sel       = PcPlus4;
    alumux1_sel     = Alu1Rs1;
    alumux2_sel     = Alu2IImm;
    marmux_sel      = MarPc;
    cmpmux_sel      = CmpRs2;
    regfilemux_sel  = RfAluOut;
    aluop           = AluAdd;
    cmpop           = funct3;
    unique case (state_q)
      StFetch1: load_mar = 1'b1;
      StFetch2: begin
        mem_read = 1'b1;
        load_mdr = 1'b1;
      end
      StFetch3: load_ir = 1'b1;
      StImm, StReg: begin
        load_regfile = 1'b1;
        load_pc      = 1'b1;
        aluop        = funct3;
        if (state_q == StReg) alumux2_sel = Alu2Rs2;
        case (funct3)
          3'b010: begin
            cmpop          = CmpBlt;
            regfilemux_sel = RfBrEn;
            if (state_q == StImm) cmpmux_sel = CmpIImm;
          end
          3'b011: begin
            cmpop          = CmpBltu;
            regfilemux_sel = RfBrEn;
            if (state_q == StImm) cmpmux_sel = CmpIImm;
          end
          3'b101: if (funct7[5]) aluop = AluSra;
          3'b000: if (funct7[5] && state_q == StReg) aluop = AluSub;
          default: ;
        endcase
      end
      StLui: begin
        regfilemux_sel = RfUImm;
        load_regfile   = 1'b1;
        load_pc        = 1'b1;
      end
      StAuipc: begin
        alumux1_sel  = Alu1Pc;
        alumux2_sel  = Alu2UImm;
        load_regfile = 1'b1;
        load_pc      = 1'b1;
      end
      StBr: begin
        alumux1_sel = Alu1Pc;
        alumux2_sel = Alu2BImm;
        load_pc     = 1'b1;
        pcmux_sel   = br_en ? PcAluOut : PcPlus4;
      end
      StJal, StJalr: begin
        if (state_q == StJal) begin
          alumux1_sel = Alu1Pc;
          alumux2_sel = Alu2JImm;
        end
        pcmux_sel      = PcAluMod2;
        regfilemux_sel = RfPcPlus4;
        load_regfile   = 1'b1;
        load_pc        = 1'b1;
      end
      StNop: load_pc = 1'b1;
      StCalcAddr: begin
        marmux_sel = MarAlu;
        load_mar   = 1'b1;
        if (opcode == OpStore) begin
          alumux2_sel   = Alu2SImm;
          load_data_out = 1'b1;
        end
      end
      StLd1: begin
        mem_read = 1'b1;
        load_mdr = 1'b1;
      end
      StLd2: begin
        load_regfile = 1'b1;
        load_pc      = 1'b1;
        case (funct3)
          3'b000:  regfilemux_sel = RfLb;
          3'b001:  regfilemux_sel = RfLh;
          3'b100:  regfilemux_sel = RfLbu;
          3'b101:  regfilemux_sel = RfLhu;
          default: regfilemux_sel = RfLw;
        endcase
      end
      StSt1: begin
        mem_write = 1'b1;
        case (funct3)
          3'b000:  mem_byte_enable = 4'b0001 << mem_addr_mask;
          3'b001:  mem_byte_enable = 4'b0011 << {mem_addr_mask[1], 1'b0};
          default: mem_byte_enable = 4'b1111;
        endcase
      end
      StSt2: load_pc = 1'b1;
      default: ;
    endcase
    if (!rst) begin
      load_pc       = 1'b0;
      load_ir       = 1'b0;
      load_regfile  = 1'b0;
      load_mar      = 1'b0;
      load_mdr      = 1'b0;
      load_data_out = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
    end
  end

endmodule

// File: tb/tb_cpu_control.sv
// Directed bench for cpu_control: walks instructions through the FSM and checks the controls
// seen in each state against hand-computed values.
module tb_cpu_control;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [6:0] opcode = '0;
  logic [2:0] funct3 = '0;
  logic [6:0] funct7 = '0;
  logic       br_en = 1'b0;
  logic [1:0] mem_addr_mask = '0;
  logic       mem_resp = 1'b0;
  logic       load_pc, load_ir, load_regfile, load_mar, load_mdr, load_data_out;
  logic [1:0] pcmux_sel;
  logic       alumux1_sel;
  logic [2:0] alumux2_sel;
  logic [3:0] regfilemux_sel;
  logic       marmux_sel, cmpmux_sel;
  logic [2:0] aluop, cmpop;
  logic       mem_read, mem_write;
  logic [3:0] mem_byte_enable;

  int n_checks = 0;
  int n_fail = 0;

  cpu_control dut (
    .clk            (clk),
    .rst            (rst),
    .opcode         (opcode),
    .funct3         (funct3),
    .funct7         (funct7),
    .br_en          (br_en),
    .mem_addr_mask  (mem_addr_mask),
    .mem_resp       (mem_resp),
    .load_pc        (load_pc),
    .load_ir        (load_ir),
    .load_regfile   (load_regfile),
    .load_mar       (load_mar),
    .load_mdr       (load_mdr),
    .load_data_out  (load_data_out),
    .pcmux_sel      (pcmux_sel),
    .alumux1_sel    (alumux1_sel),
    .alumux2_sel    (alumux2_sel),
    .regfilemux_sel (regfilemux_sel),
    .marmux_sel     (marmux_sel),
    .cmpmux_sel     (cmpmux_sel),
    .aluop          (aluop),
    .cmpop          (cmpop),
    .mem_read       (mem_read),
    .mem_write      (mem_write),
    .mem_byte_enable(mem_byte_enable)
  );

  always #5 clk = ~clk;

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // From inside a FETCH1 cycle, runs a one-wait fetch and stops inside the execute state.
  task automatic do_fetch(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
    opcode = op;
    funct3 = f3;
    funct7 = f7;
    mem_resp = 1'b0;
    next_cycle();
    mem_resp = 1'b1;
    next_cycle();
    mem_resp = 1'b0;
    next_cycle();
    next_cycle();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    next_cycle();
    next_cycle();
    @(negedge clk);
    n_checks++;
    if ({load_mar, load_pc, load_ir, load_mdr, mem_read, mem_write} !== 6'b000000) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b want 000000",
               {load_mar, load_pc, load_ir, load_mdr, mem_read, mem_write});
    end
    next_cycle();
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({load_mar, marmux_sel, mem_read, load_ir} !== 4'b1000) begin
      n_fail++;
      $display("FAIL release_fetch1: got %b want 1000", {load_mar, marmux_sel, mem_read, load_ir});
    end
  endtask

  task automatic test_fetch_addi();
    opcode = 7'b0010011;
    funct3 = 3'b000;
    funct7 = 7'b0000000;
    mem_resp = 1'b0;
    for (int c = 0; c < 2; c++) begin
      next_cycle();
      mem_resp = (c == 1);
      @(negedge clk);
      n_checks++;
      if ({mem_read, load_mdr, load_mar} !== 3'b110) begin
        n_fail++;
        $display("FAIL fetch2_cycle%0d: got %b want 110", c, {mem_read, load_mdr, load_mar});
      end
    end
    next_cycle();
    mem_resp = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({load_ir, mem_read, load_mdr} !== 3'b100) begin
      n_fail++;
      $display("FAIL fetch3: got %b want 100", {load_ir, mem_read, load_mdr});
    end
    next_cycle();
    @(negedge clk);
    n_checks++;
    if ({load_ir, load_pc, load_regfile, load_mar, load_mdr, mem_read} !== 6'b000000) begin
      n_fail++;
      $display("FAIL decode_idle: got %b want 000000",
               {load_ir, load_pc, load_regfile, load_mar, load_mdr, mem_read});
    end
    next_cycle();
    @(negedge clk);
    n_checks++;
    if ({load_regfile, load_pc, aluop, alumux1_sel, alumux2_sel, pcmux_sel, regfilemux_sel}
        !== {1'b1, 1'b1, 3'b000, 1'b0, 3'b000, 2'b00, 4'b0000}) begin
      n_fail++;
      $display("FAIL imm_addi: got %b want 11000000000000",
               {load_regfile, load_pc, aluop, alumux1_sel, alumux2_sel, pcmux_sel, regfilemux_sel});
    end
    next_cycle();
    @(negedge clk);
    n_checks++;
    if ({load_mar, marmux_sel, load_pc} !== 3'b100) begin
      n_fail++;
      $display("FAIL addi_to_fetch1: got %b want 100", {load_mar, marmux_sel, load_pc});
    end
  endtask

  // Vector: {load_regfile, load_pc, alumux2, cmpmux, aluop, cmpop, regfilemux}
  task automatic test_alu_decode();
    logic [6:0]  ops [10];
    logic [2:0]  f3s [10];
    logic [6:0]  f7s [10];
    logic [15:0] exp_v [10];
    ops = '{7'h33, 7'h33, 7'h33, 7'h33, 7'h33, 7'h33, 7'h13, 7'h13, 7'h13, 7'h13};
    f3s = '{3'b000, 3'b000, 3'b101, 3'b101, 3'b010, 3'b011, 3'b010, 3'b011, 3'b101, 3'b000};
    f7s = '{7'h20, 7'h00, 7'h20, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h20, 7'h20};
    exp_v = '{{2'b11, 3'b101, 1'b0, 3'b011, 3'b000, 4'b0000},
              {2'b11, 3'b101, 1'b0, 3'b000, 3'b000, 4'b0000},
              {2'b11, 3'b101, 1'b0, 3'b010, 3'b101, 4'b0000},
              {2'b11, 3'b101, 1'b0, 3'b101, 3'b101, 4'b0000},
              {2'b11, 3'b101, 1'b0, 3'b010, 3'b100, 4'b0001},
              {2'b11, 3'b101, 1'b0, 3'b011, 3'b110, 4'b0001},
              {2'b11, 3'b000, 1'b1, 3'b010, 3'b100, 4'b0001},
              {2'b11, 3'b000, 1'b1, 3'b011, 3'b110, 4'b0001},
              {2'b11, 3'b000, 1'b0, 3'b010, 3'b101, 4'b0000},
              {2'b11, 3'b000, 1'b0, 3'b000, 3'b000, 4'b0000}};
    for (int i = 0; i < 10; i++) begin
      do_fetch(ops[i], f3s[i], f7s[i]);
      @(negedge clk);
      n_checks++;
      if ({load_regfile, load_pc, alumux2_sel, cmpmux_sel, aluop, cmpop, regfilemux_sel}
          !== exp_v[i]) begin
        n_fail++;
        $display("FAIL alu_decode_%0d: got %b want %b", i,
                 {load_regfile, load_pc, alumux2_sel, cmpmux_sel, aluop, cmpop, regfilemux_sel},
                 exp_v[i]);
      end
      next_cycle();
    end
  endtask

  task automatic test_branch();
    logic [1:0] exp_pc [2];
    exp_pc = '{2'b01, 2'b00};
    for (int i = 0; i < 2; i++) begin
      br_en = (i == 0);
      do_fetch(7'b1100011, 3'b000, 7'h00);
      @(negedge clk);
      n_checks++;
      if ({load_pc, load_regfile, pcmux_sel, alumux1_sel, alumux2_sel, aluop, cmpop}
          !== {1'b1, 1'b0, exp_pc[i], 1'b1, 3'b010, 3'b000, 3'b000}) begin
        n_fail++;
        $display("FAIL beq_br_en%0d: got %b want %b", 1 - i,
                 {load_pc, load_regfile, pcmux_sel, alumux1_sel, alumux2_sel, aluop, cmpop},
                 {1'b1, 1'b0, exp_pc[i], 1'b1, 3'b010, 3'b000, 3'b000});
      end
      next_cycle();
    end
    br_en = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({load_mar, marmux_sel} !== 2'b10) begin
      n_fail++;
      $display("FAIL br_to_fetch1: got %b want 10", {load_mar, marmux_sel});
    end
  endtask

  // Vector: {load_regfile, load_pc, pcmux, alumux1, alumux2, aluop, regfilemux}
  task automatic test_upper_jump();
    logic [6:0]  ops [4];
    logic [14:0] exp_v [4];
    ops = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111};
    exp_v = '{{2'b11, 2'b00, 1'b0, 3'b000, 3'b000, 4'b0010},
              {2'b11, 2'b00, 1'b1, 3'b001, 3'b000, 4'b0000},
              {2'b11, 2'b10, 1'b1, 3'b100, 3'b000, 4'b0100},
              {2'b11, 2'b10, 1'b0, 3'b000, 3'b000, 4'b0100}};
    for (int i = 0; i < 4; i++) begin
      do_fetch(ops[i], 3'b000, 7'h00);
      @(negedge clk);
      n_checks++;
      if ({load_regfile, load_pc, pcmux_sel, alumux1_sel, alumux2_sel, aluop, regfilemux_sel}
          !== exp_v[i]) begin
        n_fail++;
        $display("FAIL upper_jump_%0d: got %b want %b", i,
                 {load_regfile, load_pc, pcmux_sel, alumux1_sel, alumux2_sel, aluop,
                  regfilemux_sel}, exp_v[i]);
      end
      next_cycle();
    end
  endtask

  task automatic test_store();
    logic [2:0] f3s [5];
    logic [1:0] masks [5];
    logic [3:0] exp_be [5];
    f3s = '{3'b000, 3'b001, 3'b010, 3'b000, 3'b001};
    masks = '{2'b10, 2'b10, 2'b01, 2'b11, 2'b01};
    exp_be = '{4'b0100, 4'b1100, 4'b1111, 4'b1000, 4'b0011};
    for (int i = 0; i < 5; i++) begin
      mem_addr_mask = masks[i];
      do_fetch(7'b0100011, f3s[i], 7'h00);
      @(negedge clk);
      n_checks++;
      if ({load_mar, marmux_sel, alumux2_sel, aluop, load_data_out, mem_write}
          !== {1'b1, 1'b1, 3'b011, 3'b000, 1'b1, 1'b0}) begin
        n_fail++;
        $display("FAIL st_calc_addr_%0d: got %b want 11011000010", i,
                 {load_mar, marmux_sel, alumux2_sel, aluop, load_data_out, mem_write});
      end
      for (int c = 0; c < 3; c++) begin
        next_cycle();
        mem_resp = (c == 2);
        @(negedge clk);
        n_checks++;
        if ({mem_write, mem_read, mem_byte_enable, load_pc} !== {1'b1, 1'b0, exp_be[i], 1'b0})
        begin
          n_fail++;
          $display("FAIL st1_%0d_cycle%0d: got %b want %b", i, c,
                   {mem_write, mem_read, mem_byte_enable, load_pc},
                   {1'b1, 1'b0, exp_be[i], 1'b0});
        end
      end
      next_cycle();
      mem_resp = 1'b0;
      @(negedge clk);
      n_checks++;
      if ({mem_write, load_pc, mem_byte_enable} !== 6'b010000) begin
        n_fail++;
        $display("FAIL st2_%0d: got %b want 010000", i, {mem_write, load_pc, mem_byte_enable});
      end
      next_cycle();
      @(negedge clk);
      n_checks++;
      if ({load_mar, marmux_sel, mem_write} !== 3'b100) begin
        n_fail++;
        $display("FAIL st_to_fetch1_%0d: got %b want 100", i, {load_mar, marmux_sel, mem_write});
      end
    end
  endtask

  task automatic test_load();
    logic [2:0] f3s [3];
    logic [3:0] exp_rf [3];
    f3s = '{3'b100, 3'b011, 3'b001};
    exp_rf = '{4'b0110, 4'b0011, 4'b0111};
    for (int i = 0; i < 3; i++) begin
      do_fetch(7'b0000011, f3s[i], 7'h00);
      @(negedge clk);
      n_checks++;
      if ({load_mar, marmux_sel, alumux2_sel, load_data_out} !== 6'b110000) begin
        n_fail++;
        $display("FAIL ld_calc_addr_%0d: got %b want 110000", i,
                 {load_mar, marmux_sel, alumux2_sel, load_data_out});
      end
      for (int c = 0; c < 2; c++) begin
        next_cycle();
        mem_resp = (c == 1);
        @(negedge clk);
        n_checks++;
        if ({mem_read, load_mdr, mem_write, load_regfile} !== 4'b1100) begin
          n_fail++;
          $display("FAIL ld1_%0d_cycle%0d: got %b want 1100", i, c,
                   {mem_read, load_mdr, mem_write, load_regfile});
        end
      end
      next_cycle();
      mem_resp = 1'b0;
      @(negedge clk);
      n_checks++;
      if ({mem_read, load_regfile, load_pc, regfilemux_sel} !== {3'b011, exp_rf[i]}) begin
        n_fail++;
        $display("FAIL ld2_%0d: got %b want %b", i,
                 {mem_read, load_regfile, load_pc, regfilemux_sel}, {3'b011, exp_rf[i]});
      end
      next_cycle();
    end
  endtask

  task automatic test_reset_mid_load();
    do_fetch(7'b0000011, 3'b010, 7'h00);
    next_cycle();
    mem_resp = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({mem_read, load_mdr} !== 2'b11) begin
      n_fail++;
      $display("FAIL ld1_before_reset: got %b want 11", {mem_read, load_mdr});
    end
    #1;
    rst = 1'b0;
    #1;
    n_checks++;
    if ({mem_read, load_mdr, mem_write, load_regfile} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_in_ld1: got %b want 0000", {mem_read, load_mdr, mem_write, load_regfile});
    end
    next_cycle();
    next_cycle();
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({load_mar, marmux_sel, mem_read, load_mdr} !== 4'b1000) begin
      n_fail++;
      $display("FAIL fetch1_after_reset: got %b want 1000",
               {load_mar, marmux_sel, mem_read, load_mdr});
    end
  endtask

  task automatic test_nop();
    do_fetch(7'b0000000, 3'b000, 7'h00);
    @(negedge clk);
    n_checks++;
    if ({load_pc, load_regfile, load_mar, mem_read, mem_write, load_ir} !== 6'b100000) begin
      n_fail++;
      $display("FAIL nop: got %b want 100000",
               {load_pc, load_regfile, load_mar, mem_read, mem_write, load_ir});
    end
    next_cycle();
    @(negedge clk);
    n_checks++;
    if ({load_mar, marmux_sel, load_pc} !== 3'b100) begin
      n_fail++;
      $display("FAIL nop_to_fetch1: got %b want 100", {load_mar, marmux_sel, load_pc});
    end
  endtask

  initial begin
    test_reset();
    test_fetch_addi();
    test_branch();
    test_alu_decode();
    test_upper_jump();
    test_store();
    test_load();
    test_reset_mid_load();
    test_nop();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cpu_control.md
# cpu_control

Multicycle control FSM for the RV32I datapath. It decodes `opcode`/`funct3`/`funct7` from the datapath IR and sequences fetch, decode, execute and memory phases. It drives every register load enable, mux select, `aluop` and `cmpop` into the datapath. It also owns the memory handshake (`mem_read`/`mem_write`/`mem_resp`) and generates the store byte enables.

## Interface
- No parameters; all select widths come from the `rv32i_types` and mux-type packages.
- `clk` in 1: rising-edge clock.
- `rst` in 1: asynchronous, active-low reset.
- `opcode` in 7 (`rv32i_opcode`): from IR.
- `funct3` in 3: from IR.
- `funct7` in 7: from IR.
- `br_en` in 1: from CMP.
- `mem_addr_mask` in 2: MAR[1:0].
- `mem_resp` in 1: memory done, one-cycle pulse.
- `load_pc`, `load_ir`, `load_regfile`, `load_mar`, `load_mdr`, `load_data_out` out 1 each: register load enables.
- `pcmux_sel`, `alumux1_sel`, `alumux2_sel`, `regfilemux_sel`, `marmux_sel`, `cmpmux_sel` out (enum width): datapath mux selects.
- `aluop` out 3 (`alu_ops`): ALU operation.
- `cmpop` out 3 (`branch_funct3_t`): comparator operation.
- `mem_read`, `mem_write` out 1: memory requests.
- `mem_byte_enable` out 4: store byte lanes.

## Operation
- States: FETCH1, FETCH2, FETCH3, DECODE, IMM, REG, LUI, AUIPC, BR, JAL, JALR, NOP, CALC_ADDR, LD1, LD2, ST1, ST2.
- Output defaults every state:
  - all loads 0, `mem_read`/`mem_write` 0, `mem_byte_enable` 4'b0000;
  - `pcmux` pc_plus4, `alumux1` rs1_out, `alumux2` i_imm, `marmux` pc_out, `cmpmux` rs2_out, `regfilemux` alu_out;
  - `aluop` alu_add, `cmpop` = funct3.
- Fetch and decode:
  - FETCH1: `load_mar`, `marmux` pc_out → FETCH2.
  - FETCH2: `mem_read`, `load_mdr`; stay while `mem_resp`=0; → FETCH3 on `mem_resp`=1.
  - FETCH3: `load_ir` → DECODE.
  - DECODE: no outputs. Dispatch: op_imm→IMM, op_reg→REG, op_lui→LUI, op_auipc→AUIPC, op_br→BR, op_jal→JAL, op_jalr→JALR, op_load/op_store→CALC_ADDR, any other opcode→NOP.
- IMM: `load_regfile`, `load_pc`, `aluop`=funct3.
  - slti: `cmpop` blt, `cmpmux` i_imm, `regfilemux` br_en.
  - sltiu: same with `cmpop` bltu.
  - funct3=101 with funct7[5]=1: `aluop` alu_sra.
- REG: as IMM but `alumux2` rs2_out, `cmpmux` rs2_out.
  - funct3=000 with funct7[5]=1: `aluop` alu_sub.
  - funct3=101 with funct7[5]=1: `aluop` alu_sra.
- LUI: `regfilemux` u_imm, `load_regfile`, `load_pc`.
- AUIPC: `alumux1` pc_out, `alumux2` u_imm, add, `load_regfile`, `load_pc`.
- BR: `alumux1` pc_out, `alumux2` b_imm, add, `load_pc`; `pcmux` alu_out if `br_en`, else pc_plus4.
- JAL: `alumux1` pc_out, `alumux2` j_imm, `pcmux` alu_mod2, `regfilemux` pc_plus4, `load_regfile`, `load_pc`.
- JALR: `alumux1` rs1_out, `alumux2` i_imm, `pcmux` alu_mod2, `regfilemux` pc_plus4, `load_regfile`, `load_pc`.
- NOP: `load_pc` only. No register write.
- CALC_ADDR: `alumux2` i_imm for loads / s_imm for stores, add, `marmux` alu_out, `load_mar`. Stores also assert `load_data_out`. → LD1 or ST1.
- LD1: `mem_read`, `load_mdr`; hold until `mem_resp` → LD2.
- LD2: `load_regfile`, `load_pc`; `regfilemux` from funct3: lb/lh/lw/lbu/lhu, undefined funct3 → lw.
- ST1: `mem_write`; hold until `mem_resp` → ST2. Byte enables:
  - sb: 4'b0001 << `mem_addr_mask`;
  - sh: 4'b0011 << {`mem_addr_mask`[1],1'b0};
  - sw or other funct3: 4'b1111.
- ST2: `load_pc` → FETCH1.
- All execute terminal states → FETCH1.
- Writes to x0 are filtered by the regfile, not here.

## Timing
- State register is clocked. Outputs are combinational from state, plus `br_en`/`funct*`/`mem_addr_mask`.
- `rst`=0: state forced to FETCH1 asynchronously; all load, `mem_read` and `mem_write` outputs forced 0 combinationally while `rst`=0.
  - First active cycle after release is FETCH1.
  - Reset mid-request drops `mem_read`/`mem_write` immediately.
- Memory handshake:
  - `mem_read`/`mem_write` are held constant from state entry until the cycle `mem_resp`=1 is sampled.
  - They deassert the following cycle.
  - The MDR captures on the `mem_resp` edge.
- Latency with `mem_resp` returned in the first request cycle:
  - ALU/LUI/AUIPC/branch/jump/NOP: 5 cycles.
  - Load/store: 7 cycles.
  - Each extra wait cycle adds 1.

## Test plan
- Reset, then fetch `addi x1,x0,5` (0x00500093) with `mem_resp` on the 2nd FETCH2 cycle → FETCH1, FETCH2×2, FETCH3, DECODE, IMM. IMM drives `load_regfile`=1, `aluop`=add, `alumux2`=i_imm, `load_pc`=1, `pcmux`=pc_plus4.
- beq (funct3 000) in BR: `br_en`=1 → `pcmux`=alu_out, `alumux2`=b_imm; `br_en`=0 → `pcmux`=pc_plus4. `load_pc`=1 in both cases.
- Store `mem_byte_enable` checks, `mem_write` held 3 cycles until `mem_resp` and deasserted the next cycle:
  - sb with `mem_addr_mask`=2'b10 → 4'b0100;
  - sh with mask 2'b10 → 4'b1100;
  - sw → 4'b1111.
- REG decode:
  - funct7=0100000, funct3=000 → `aluop` sub;
  - funct3=101, funct7=0100000 → sra;
  - funct3=010 → `regfilemux` br_en, `cmpop` blt;
  - funct3=011 → bltu.
- Assert `rst`=0 during LD1 with `mem_read`=1 → `mem_read`=0 and `load_mdr`=0 in the same cycle; after release the state is FETCH1 and `load_mar`=1.
- Opcode 7'b0000000 → DECODE→NOP: `load_pc`=1, `load_regfile`=0, then FETCH1.
